alu_op_decoder: RTL and testbench

- Decode stage that produces the ALU opcodes the ALU consumes.
- Takes fetched RV32I instructions with their PC and emits a registered decode bundle: ALU opcode, operand selects, immediate, register addresses and control flags.
- Sits between fetch and execute, with valid/ready on both sides.
- A 2-entry skid buffer keeps full throughput while in_ready_o stays a registered signal.

---
 rtl/alu_op_decoder_pkg.sv | 52 +++++
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_decoder_comb.sv | 132 +++++++++++++
 rtl/alu_op_decoder.sv | 139 +++++++++++++
 tb/tb_alu_op_decoder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_decoder_pkg.sv
// ============================================================================
// Module  : alu_op_decoder_pkg
// Brief   : RV32I opcodes, operand-select enums and the decode bundle type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_op_decoder_pkg;

    import alu_pkg::*;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_RS2  = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_FOUR = 2'd2
    } b_sel_e;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] alu_op;
        a_sel_e                  a_sel;
        b_sel_e                  b_sel;
        logic [31:0]             imm;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic                    gpr_we;
        logic                    branch;
        logic                    jump;
        logic                    mem_req;
        logic                    mem_we;
        logic                    illegal;
    } decode_t;

endpackage

`default_nettype wire

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : ALU opcode encoding shared by the ALU and its decode stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_OP_WIDTH = 5;

    // {branch, sub/arith, funct3} for register ops; {2'b11, funct3} for compares
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 5'b00010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BEQ  = 5'b11000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BNE  = 5'b11001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BLT  = 5'b11100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BGE  = 5'b11101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BLTU = 5'b11110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BGEU = 5'b11111;

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder_comb.sv
// ============================================================================
// Module  : alu_op_decoder_comb
// Brief   : Purely combinational RV32I instruction to decode-bundle mapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder_comb
    import alu_pkg::*;
    import alu_op_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];

        // Anything left unassigned below falls through to the illegal default.
        case (w_opcode)
            OPCODE_OP: begin
                if (w_f7 == 7'b0000000 ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    dec.alu_op = {1'b0, w_f7[5], w_f3};
                    dec.gpr_we = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                if ((w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = {1'b0, w_f7[5] & (w_f3 == 3'b101), w_f3};
                    dec.b_sel  = B_SEL_IMM;
                    // Shifts carry only the shamt so funct7 does not leak into the amount
                    dec.imm    = (w_f3 == 3'b001 || w_f3 == 3'b101) ?
                                 {27'b0, instr[24:20]} : w_imm_i;
                    dec.gpr_we = 1'b1;
                end
            end
            OPCODE_BRANCH: begin
                if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = {2'b11, w_f3};
                    dec.imm    = w_imm_b;
                    dec.branch = 1'b1;
                end
            end
            OPCODE_LUI: begin
                dec.a_sel  = A_SEL_ZERO;
                dec.b_sel  = B_SEL_IMM;
                dec.imm    = w_imm_u;
                dec.gpr_we = 1'b1;
            end
            OPCODE_AUIPC: begin
                dec.a_sel  = A_SEL_PC;
                dec.b_sel  = B_SEL_IMM;
                dec.imm    = w_imm_u;
                dec.gpr_we = 1'b1;
            end
            OPCODE_LOAD: begin
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.b_sel   = B_SEL_IMM;
                    dec.imm     = w_imm_i;
                    dec.gpr_we  = 1'b1;
                    dec.mem_req = 1'b1;
                end
            end
            OPCODE_STORE: begin
                if (w_f3[2] || w_f3 == 3'b011) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.b_sel   = B_SEL_IMM;
                    dec.imm     = w_imm_s;
                    dec.mem_req = 1'b1;
                    dec.mem_we  = 1'b1;
                end
            end
            OPCODE_JAL: begin
                dec.a_sel  = A_SEL_PC;
                dec.b_sel  = B_SEL_FOUR;
                dec.imm    = w_imm_j;
                dec.gpr_we = 1'b1;
                dec.jump   = 1'b1;
            end
            OPCODE_JALR: begin
                if (w_f3 != 3'b000) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.a_sel  = A_SEL_PC;
                    dec.b_sel  = B_SEL_FOUR;
                    dec.imm    = w_imm_i;
                    dec.gpr_we = 1'b1;
                    dec.jump   = 1'b1;
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
// Module  : alu_op_decoder
// Brief   : Registered RV32I decode stage with 2-entry skid buffer and
//           saturating illegal-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
    import alu_pkg::*;
    import alu_op_decoder_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ALU_OP_WIDTH-1:0]  alu_op_o,
    output logic [1:0]               a_sel_o,
    output logic [1:0]               b_sel_o,
    output logic [XLEN-1:0]          imm_o,
    output logic [4:0]               rs1_o,
    output logic [4:0]               rs2_o,
    output logic [4:0]               rd_o,
    output logic                     gpr_we_o,
    output logic                     branch_o,
    output logic                     jump_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic                     illegal_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt_o
);

    decode_t                  w_dec;
    logic                     w_accept;
    logic                     w_drain;

    decode_t                  r_out;
    logic [XLEN-1:0]          r_out_pc;
    logic                     r_out_valid;
    decode_t                  r_skid;
    logic [XLEN-1:0]          r_skid_pc;
    logic                     r_skid_valid;
    logic                     r_in_ready;
    logic [ILLEGAL_CNT_W-1:0] r_illegal_cnt;

    alu_op_decoder_comb u_comb (
        .instr (instr_i),
        .dec   (w_dec)
    );

    assign w_accept = in_valid_i && r_in_ready;
    assign w_drain  = !r_out_valid || out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out        <= '0;
            r_out_pc     <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                // Oldest entry lives in the skid; it moves up before any new accept.
                r_out        <= r_skid;
                r_out_pc     <= r_skid_pc;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_accept;
                r_in_ready   <= !w_accept;
                if (w_accept) begin
                    r_skid    <= w_dec;
                    r_skid_pc <= pc_i;
                end
            end else begin
                r_out_valid <= w_accept;
                r_in_ready  <= 1'b1;
                if (w_accept) begin
                    r_out    <= w_dec;
                    r_out_pc <= pc_i;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_pc    <= pc_i;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal_cnt <= '0;
        end else if (r_out_valid && out_ready_i && r_out.illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    generate
        if (XLEN > 32) begin : g_imm_sext
            assign imm_o = {{(XLEN-32){r_out.imm[31]}}, r_out.imm};
        end else begin : g_imm_trunc
            assign imm_o = r_out.imm[XLEN-1:0];
        end
    endgenerate

    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = r_out_valid;
    assign alu_op_o      = r_out.alu_op;
    assign a_sel_o       = r_out.a_sel;
    assign b_sel_o       = r_out.b_sel;
    assign rs1_o         = r_out.rs1;
    assign rs2_o         = r_out.rs2;
    assign rd_o          = r_out.rd;
    assign gpr_we_o      = r_out.gpr_we;
    assign branch_o      = r_out.branch;
    assign jump_o        = r_out.jump;
    assign mem_req_o     = r_out.mem_req;
    assign mem_we_o      = r_out.mem_we;
    assign illegal_o     = r_out.illegal;
    assign pc_o          = r_out_pc;
    assign illegal_cnt_o = r_illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
// ============================================================================
// Module  : tb_alu_op_decoder
// Brief   : Scoreboard bench for alu_op_decoder with directed RV32I vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        gpr_we;
    logic        branch;
    logic        jump;
    logic        mem_req;
    logic        mem_we;
    logic        illegal;
    logic [31:0] pc_out;
    logic [15:0] illegal_cnt;

    always #5 clk = ~clk;

    alu_op_decoder #(.XLEN(32), .ILLEGAL_CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .instr_i       (instr),
        .pc_i          (pc),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .alu_op_o      (alu_op),
        .a_sel_o       (a_sel),
        .b_sel_o       (b_sel),
        .imm_o         (imm),
        .rs1_o         (rs1),
        .rs2_o         (rs2),
        .rd_o          (rd),
        .gpr_we_o      (gpr_we),
        .branch_o      (branch),
        .jump_o        (jump),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .illegal_o     (illegal),
        .pc_o          (pc_out),
        .illegal_cnt_o (illegal_cnt)
    );

    // flags = {gpr_we, branch, jump, mem_req, mem_we, illegal}
    typedef struct packed {
        logic [4:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [5:0]  flags;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;

    function automatic exp_t mk(input logic [4:0] alu, input logic [1:0] a, input logic [1:0] b,
                                input logic [31:0] im, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [5:0] fl, input logic [31:0] p);
        exp_t e;
        e.alu = alu; e.a = a; e.b = b; e.imm = im; e.rd = d; e.rs1 = s1; e.rs2 = s2;
        e.flags = fl; e.pc = p;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] p, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (instr %08h)", ins);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_act = {alu_op, a_sel, b_sel, imm, rd, rs1, rs2,
                       gpr_we, branch, jump, mem_req, mem_we, illegal, pc_out};
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL bundle: got unexpected %0h expected none", mon_act);
            end else begin
                mon_exp = sb.pop_front();
                n_popped++;
                if (mon_act === mon_exp) n_pass++;
                else $display("FAIL bundle#%0d: got %0h expected %0h", n_popped, mon_act, mon_exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        chk("rst_bundle", {alu_op, imm, rd, gpr_we, pc_out}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream, one per cycle
        send(32'h002081B3, 32'h100, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h100));
        chk("latency_add", out_valid, 1);
        send(32'h402081B3, 32'h104, mk(5'b01000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h104));
        chk("latency_sub", out_valid, 1);
        send(32'h40335293, 32'h108, mk(5'b01101, 2'd0, 2'd1, 32'h3, 5'd5, 5'd6, 5'd3, 6'b100000, 32'h108));
        send(32'h0020C063, 32'h10C, mk(5'b11100, 2'd0, 2'd0, 32'h0, 5'd0, 5'd1, 5'd2, 6'b010000, 32'h10C));
        send(32'h00000000, 32'h110, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000001, 32'h110));
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_cnt_1", illegal_cnt, 1);

        send(32'h123452B7, 32'h114, mk(5'b00000, 2'd2, 2'd1, 32'h12345000, 5'd5, 5'd8, 5'd3, 6'b100000, 32'h114));
        send(32'h008000EF, 32'h118, mk(5'b00000, 2'd1, 2'd2, 32'h8, 5'd1, 5'd0, 5'd8, 6'b101000, 32'h118));
        send(32'h0020A223, 32'h11C, mk(5'b00000, 2'd0, 2'd1, 32'h4, 5'd4, 5'd1, 5'd2, 6'b000110, 32'h11C));
        send(32'hFFC0A283, 32'h120, mk(5'b00000, 2'd0, 2'd1, 32'hFFFFFFFC, 5'd5, 5'd1, 5'd28, 6'b100100, 32'h120));
        send(32'h002081B0, 32'h124, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b000001, 32'h124));
        send(32'h40309293, 32'h128, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd5, 5'd1, 5'd3, 6'b000001, 32'h128));
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_cnt_3", illegal_cnt, 3);

        // Stall: output and skid fill, third instruction waits
        out_ready = 1'b0;
        send(32'h002081B3, 32'h200, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h200));
        send(32'h402081B3, 32'h204, mk(5'b01000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h204));
        chk("skid_full_ready", in_ready, 0);
        fork
            send(32'h123452B7, 32'h208, mk(5'b00000, 2'd2, 2'd1, 32'h12345000, 5'd5, 5'd8, 5'd3, 6'b100000, 32'h208));
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold", {alu_op, pc_out}, {5'b00000, 32'h200});
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", sb.size(), 0);
        chk("stall_idle", out_valid, 0);

        // Flush with output and skid both full
        out_ready = 1'b0;
        send(32'h008000EF, 32'h300, mk(5'b00000, 2'd1, 2'd2, 32'h8, 5'd1, 5'd0, 5'd8, 6'b101000, 32'h300));
        send(32'h0020A223, 32'h304, mk(5'b00000, 2'd0, 2'd1, 32'h4, 5'd4, 5'd1, 5'd2, 6'b000110, 32'h304));
        flush = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);

        // Accept coinciding with flush is dropped
        send(32'h002081B3, 32'h308, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h308));
        flush = 1'b1; in_valid = 1'b1; instr = 32'h402081B3; pc = 32'h30C;
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(32'h40335293, 32'h310, mk(5'b01101, 2'd0, 2'd1, 32'h3, 5'd5, 5'd6, 5'd3, 6'b100000, 32'h310));
        repeat (3) @(posedge clk);
        #1;
        chk("post_flush_drained", sb.size(), 0);
        chk("illegal_cnt_flush", illegal_cnt, 3);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(32'h002081B3, 32'h400, mk(5'b00000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h400));
        send(32'h402081B3, 32'h404, mk(5'b01000, 2'd0, 2'd0, 32'h0, 5'd3, 5'd1, 5'd2, 6'b100000, 32'h404));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_bundle", {alu_op, imm, rd, rs1, gpr_we, pc_out}, 0);
        chk("arst_illegal_cnt", illegal_cnt, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h0020C063, 32'h408, mk(5'b11100, 2'd0, 2'd0, 32'h0, 5'd0, 5'd1, 5'd2, 6'b010000, 32'h408));
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
